// File: rtl/switch_in_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_in_pkg
//  Description : Shared constants for the switch/button input peripheral:
//                register offsets, FLAGS bit positions, prescaler width.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_in_pkg;

    // Width of the debounce prescaler counter (covers DEBOUNCE_CYCLES <= 65535)
    localparam int PRESC_W = 16;

    // Register offsets relative to BASE_ADDR
    typedef enum logic [1:0] {
        REG_SW_LO = 2'd0,
        REG_SW_HI = 2'd1,
        REG_BTN   = 2'd2,
        REG_FLAGS = 2'd3
    } reg_off_e;

    // FLAGS bit positions
    localparam int FLAG_BTN_LSB = 0;
    localparam int FLAG_SWLO    = 4;
    localparam int FLAG_SWHI    = 5;
    localparam int NUM_FLAGS    = 6;

    // Number of debounced inputs: 16 switches + 4 buttons
    localparam int NUM_INPUTS   = 20;

endpackage
`default_nettype wire

// File: rtl/debounce_filter.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_filter
//  Description : Two-flop synchroniser followed by a 3-sample majority-free
//                debounce: each output bit only follows its input once three
//                consecutive tick samples agree, otherwise it holds.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_filter #(
    parameter int WIDTH = 20
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_hist0;
    logic [WIDTH-1:0] r_hist1;
    logic [WIDTH-1:0] r_hist2;
    logic [WIDTH-1:0] w_agree;

    // Bring the raw asynchronous inputs into the CLK domain
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
        end
    end

    // Shift one synchronised sample into the history on every prescaler tick
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_hist0 <= '0;
            r_hist1 <= '0;
            r_hist2 <= '0;
        end else if (tick) begin
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_hist2 <= r_hist1;
        end
    end

    // A bit is stable when all three history samples match
    assign w_agree = ~(r_hist0 ^ r_hist1) & ~(r_hist1 ^ r_hist2);

    // Update stable bits, hold the rest
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            dout <= '0;
        end else begin
            dout <= (r_hist0 & w_agree) | (dout & ~w_agree);
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_in_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : switch_in_ctrl
//  Description : Bus-read peripheral returning debounced slide switches and
//                push-buttons, with sticky W1C event flags and an interrupt
//                request raised on every new event.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_in_ctrl
    import switch_in_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR       = 8'hC2,
    parameter int         DEBOUNCE_CYCLES = 50000
) (
    input  logic        CLK,
    input  logic        RESETN,
    inout  wire  [7:0]  BUS_DATA,
    input  logic [7:0]  BUS_ADDR,
    input  logic        BUS_WE,
    output logic        BUS_INTERRUPT_RAISE,
    input  logic        BUS_INTERRUPT_ACK,
    input  logic [15:0] SW,
    input  logic [3:0]  BTN
);

    localparam logic [PRESC_W-1:0] c_presc_max = PRESC_W'(DEBOUNCE_CYCLES - 1);

    logic [PRESC_W-1:0]    r_presc;
    logic                  w_tick;
    logic [NUM_INPUTS-1:0] w_db;
    logic [NUM_INPUTS-1:0] r_db_prev;
    logic [NUM_FLAGS-1:0]  w_set;
    logic [NUM_FLAGS-1:0]  w_clr;
    logic [NUM_FLAGS-1:0]  w_flags_next;
    logic [NUM_FLAGS-1:0]  r_flags;
    logic                  w_new_event;
    logic [7:0]            w_offset;
    logic                  w_hit;
    logic                  w_rd;
    logic                  w_wr_flags;
    logic [7:0]            w_rd_val;
    logic [7:0]            r_rdata;
    logic                  r_oe;
    logic                  w_drive_en;
    logic                  w_unused;

    // Free-running sample prescaler; one-cycle tick at the wrap
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_tick = (r_presc == c_presc_max);

    debounce_filter #(
        .WIDTH (NUM_INPUTS)
    ) u_debounce (
        .CLK    (CLK),
        .RESETN (RESETN),
        .tick   (w_tick),
        .din    ({BTN, SW}),
        .dout   (w_db)
    );

    // Previous debounced state for edge/change detection
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_db_prev <= '0;
        end else begin
            r_db_prev <= w_db;
        end
    end

    assign w_set[FLAG_BTN_LSB +: 4] = w_db[19:16] & ~r_db_prev[19:16];
    assign w_set[FLAG_SWLO]         = |(w_db[7:0]  ^ r_db_prev[7:0]);
    assign w_set[FLAG_SWHI]         = |(w_db[15:8] ^ r_db_prev[15:8]);

    // Address decode: offset wraps, so only BASE..BASE+3 yields offset < 4
    assign w_offset   = BUS_ADDR - BASE_ADDR;
    assign w_hit      = (w_offset[7:2] == 6'd0);
    assign w_rd       = w_hit & ~BUS_WE;
    assign w_wr_flags = w_hit & BUS_WE & (w_offset[1:0] == REG_FLAGS);

    // W1C clear mask; a set in the same cycle overrides the clear
    assign w_clr        = w_wr_flags ? BUS_DATA[NUM_FLAGS-1:0] : '0;
    assign w_flags_next = (r_flags & ~w_clr) | w_set;
    assign w_new_event  = |(w_flags_next & ~r_flags);

    // Upper data bits carry no writable flag
    assign w_unused = &{1'b0, BUS_DATA[7:NUM_FLAGS]};

    // Sticky event flags
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags_next;
        end
    end

    // Interrupt request: a new event beats a simultaneous acknowledge
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else if (w_new_event) begin
            BUS_INTERRUPT_RAISE <= 1'b1;
        end else if (BUS_INTERRUPT_ACK) begin
            BUS_INTERRUPT_RAISE <= 1'b0;
        end
    end

    // Read-data selection
    always_comb begin
        w_rd_val = 8'h00;
        case (reg_off_e'(w_offset[1:0]))
            REG_SW_LO: w_rd_val = w_db[7:0];
            REG_SW_HI: w_rd_val = w_db[15:8];
            REG_BTN:   w_rd_val = {4'b0000, w_db[19:16]};
            REG_FLAGS: w_rd_val = {2'b00, r_flags};
            default:   w_rd_val = 8'h00;
        endcase
    end

    // Register the read response one cycle behind its address
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rdata <= 8'h00;
            r_oe    <= 1'b0;
        end else if (w_rd) begin
            r_rdata <= w_rd_val;
            r_oe    <= 1'b1;
        end else begin
            r_oe    <= 1'b0;
        end
    end

    // Never contend with a bus master that is writing
    assign w_drive_en = r_oe & ~BUS_WE;
    assign BUS_DATA   = w_drive_en ? r_rdata : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_switch_in_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_in_ctrl
//  Description : Self-checking bench for switch_in_ctrl (DEBOUNCE_CYCLES = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_in_ctrl;

    logic        CLK;
    logic        RESETN;
    logic [7:0]  BUS_ADDR;
    logic        BUS_WE;
    logic        BUS_INTERRUPT_ACK;
    logic        BUS_INTERRUPT_RAISE;
    logic [15:0] SW;
    logic [3:0]  BTN;
    logic [7:0]  tb_bus_drv;
    logic        tb_bus_en;
    wire  [7:0]  bus_data;

    int          vectors;
    int          miscompares;
    logic [7:0]  exp_q[$];
    logic [7:0]  got;
    logic [7:0]  exp;

    assign bus_data = tb_bus_en ? tb_bus_drv : 8'hzz;

    switch_in_ctrl #(
        .BASE_ADDR       (8'hC2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLK                 (CLK),
        .RESETN              (RESETN),
        .BUS_DATA            (bus_data),
        .BUS_ADDR            (BUS_ADDR),
        .BUS_WE              (BUS_WE),
        .BUS_INTERRUPT_RAISE (BUS_INTERRUPT_RAISE),
        .BUS_INTERRUPT_ACK   (BUS_INTERRUPT_ACK),
        .SW                  (SW),
        .BTN                 (BTN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Read: address this cycle, data sampled just after the next edge
    task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
        BUS_ADDR = addr;
        BUS_WE   = 1'b0;
        @(posedge CLK);
        #1;
        data     = bus_data;
        BUS_ADDR = 8'h00;
    endtask

    task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
        BUS_ADDR   = addr;
        BUS_WE     = 1'b1;
        tb_bus_drv = data;
        tb_bus_en  = 1'b1;
        @(posedge CLK);
        #1;
        BUS_WE     = 1'b0;
        tb_bus_en  = 1'b0;
        BUS_ADDR   = 8'h00;
    endtask

    // Wait until the debounced value of filter bit idx goes high
    task automatic wait_db_high(input int idx, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge CLK);
            #1;
            if (dut.u_debounce.dout[idx] === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        logic [7:0] addrs [4];
        addrs = '{8'hC2, 8'hC3, 8'hC4, 8'hC5};
        RESETN = 1'b0;
        wait_cycles(3);
        RESETN = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 4; i++) begin
            BUS_ADDR = addrs[i];
            exp_q.push_back(8'h00);
            @(posedge CLK);
            #1;
            got = bus_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_read[%0h]: got %h expected %h", addrs[i], got, exp);
            end
        end
        BUS_ADDR = 8'h00;
        wait_cycles(1);
        vectors++;
        if (dut.w_drive_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle_float: drive_en %b expected 0", dut.w_drive_en);
        end
        vectors++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_raise: got %b expected 0", BUS_INTERRUPT_RAISE);
        end
    endtask

    task automatic test_switches;
        logic [7:0] addrs [3];
        logic [7:0] vals  [3];
        addrs = '{8'hC2, 8'hC3, 8'hC5};
        vals  = '{8'h5A, 8'hA5, 8'h30};
        SW = 16'hA55A;
        wait_cycles(20);
        for (int i = 0; i < 3; i++) begin
            BUS_ADDR = addrs[i];
            exp_q.push_back(vals[i]);
            @(posedge CLK);
            #1;
            got = bus_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL sw_read[%0h]: got %h expected %h", addrs[i], got, exp);
            end
        end
        BUS_ADDR = 8'h00;
        vectors++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_raise: got %b expected 1", BUS_INTERRUPT_RAISE);
        end
    endtask

    task automatic test_buttons;
        // Short glitch must be rejected
        BTN = 4'b0100;
        wait_cycles(6);
        BTN = 4'b0000;
        wait_cycles(24);
        exp_q.push_back(8'h00);
        bus_read(8'hC4, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL btn_glitch_reg: got %h expected %h", got, exp);
        end
        exp_q.push_back(8'h30);
        bus_read(8'hC5, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL btn_glitch_flags: got %h expected %h", got, exp);
        end
        // Held press is accepted
        BTN = 4'b0100;
        wait_cycles(20);
        exp_q.push_back(8'h04);
        bus_read(8'hC4, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL btn_press_reg: got %h expected %h", got, exp);
        end
        exp_q.push_back(8'h34);
        bus_read(8'hC5, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL btn_press_flags: got %h expected %h", got, exp);
        end
        BTN = 4'b0000;
        wait_cycles(24);
    endtask

    task automatic test_ack_and_clear;
        BUS_INTERRUPT_ACK = 1'b1;
        @(posedge CLK);
        #1;
        BUS_INTERRUPT_ACK = 1'b0;
        vectors++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_raise: got %b expected 0", BUS_INTERRUPT_RAISE);
        end
        exp_q.push_back(8'h34);
        bus_read(8'hC5, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL ack_flags_kept: got %h expected %h", got, exp);
        end
        wait_cycles(1);
        bus_write(8'hC5, 8'h04);
        bus_write(8'hC2, 8'hFF);
        exp_q.push_back(8'h30);
        bus_read(8'hC5, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL w1c_flags: got %h expected %h", got, exp);
        end
        wait_cycles(1);
    endtask

    task automatic test_collisions;
        bit found;
        // BTN[0] debounced edge coincides with a W1C of the same bit
        BTN = 4'b0001;
        wait_db_high(16, found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL btn0_timeout: got 0 expected 1");
        end
        bus_write(8'hC5, 8'h01);
        exp_q.push_back(8'h31);
        bus_read(8'hC5, got);
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL set_beats_clear: got %h expected %h", got, exp);
        end
        vectors++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) begin
            miscompares++;
            $display("FAIL btn0_raise: got %b expected 1", BUS_INTERRUPT_RAISE);
        end
        BUS_INTERRUPT_ACK = 1'b1;
        @(posedge CLK);
        #1;
        BUS_INTERRUPT_ACK = 1'b0;
        // BTN[1] debounced edge coincides with an acknowledge
        BTN = 4'b0011;
        wait_db_high(17, found);
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL btn1_timeout: got 0 expected 1");
        end
        BUS_INTERRUPT_ACK = 1'b1;
        @(posedge CLK);
        #1;
        BUS_INTERRUPT_ACK = 1'b0;
        vectors++;
        if (BUS_INTERRUPT_RAISE !== 1'b1) begin
            miscompares++;
            $display("FAIL event_beats_ack: got %b expected 1", BUS_INTERRUPT_RAISE);
        end
        BTN = 4'b0000;
        wait_cycles(24);
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] addrs [4];
        addrs = '{8'hC2, 8'hC3, 8'hC4, 8'hC5};
        BUS_ADDR = 8'hC3;
        BUS_WE   = 1'b0;
        exp_q.push_back(8'hA5);
        @(posedge CLK);
        #1;
        got = bus_data;
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp || dut.w_drive_en !== 1'b1) begin
            miscompares++;
            $display("FAIL midread_data: got %h (en %b) expected %h (en 1)", got, dut.w_drive_en, exp);
        end
        RESETN = 1'b0;
        SW     = 16'h0000;
        #1;
        vectors++;
        if (dut.w_drive_en !== 1'b0) begin
            miscompares++;
            $display("FAIL midread_float: drive_en %b expected 0", dut.w_drive_en);
        end
        BUS_ADDR = 8'h00;
        wait_cycles(3);
        RESETN = 1'b1;
        wait_cycles(2);
        for (int i = 0; i < 4; i++) begin
            BUS_ADDR = addrs[i];
            exp_q.push_back(8'h00);
            @(posedge CLK);
            #1;
            got = bus_data;
            exp = exp_q.pop_front();
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL post_reset_read[%0h]: got %h expected %h", addrs[i], got, exp);
            end
        end
        BUS_ADDR = 8'h00;
        vectors++;
        if (BUS_INTERRUPT_RAISE !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_raise: got %b expected 0", BUS_INTERRUPT_RAISE);
        end
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        RESETN            = 1'b0;
        BUS_ADDR          = 8'h00;
        BUS_WE            = 1'b0;
        BUS_INTERRUPT_ACK = 1'b0;
        SW                = 16'h0000;
        BTN               = 4'b0000;
        tb_bus_drv        = 8'h00;
        tb_bus_en         = 1'b0;
        #1;
        test_reset;
        test_switches;
        test_buttons;
        test_ack_and_clear;
        test_collisions;
        test_reset_mid_read;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
